// File: rtl/rc_pkg.sv
// Shared redundancy-controller package.
//   RC_WORD_WIDTH : default data width for indices, kernel width and distances
//   RC_MAX_REQ    : largest requester count rr_pick can arbitrate
//   dca_state_t   : distance-calculation arbiter FSM states
//   rr_pick       : round-robin winner search, reusable by other arbiters
package rc_pkg;

    localparam int unsigned RC_WORD_WIDTH = 8;
    localparam int unsigned RC_MAX_REQ    = 32;

    typedef enum logic [1:0] {
        DCA_IDLE,
        DCA_DIV,
        DCA_RESP
    } dca_state_t;

    // Returns the first set bit of req scanning upward from last+1, modulo n.
    // Result is meaningless when req has no set bit among the low n bits; callers gate on |req.
    function automatic logic [4:0] rr_pick(input logic [RC_MAX_REQ-1:0] req,
                                           input logic [4:0]            last,
                                           input int unsigned           n);
        logic [4:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= RC_MAX_REQ; i++) begin
            idx = (32'(last) + i) % n;
            if (!found && (i <= n) && req[idx[4:0]]) begin
                pick  = idx[4:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dual_idx_divider.sv
// Two-lane repeated-subtraction divider sharing one divisor.
//   clk, reset_n : clock and asynchronous active-low reset
//   start        : load idx1/idx2/kw, clear quotients, begin dividing
//   kw           : divisor, sampled on start
//   idx1, idx2   : dividends, sampled on start
//   done         : registered; both remainders below divisor (or divisor is zero)
//   q1, q2       : quotients
//   rem1, rem2   : remainders
module dual_idx_divider
    import rc_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = RC_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] kw,
    input  logic [WORD_WIDTH-1:0] idx1,
    input  logic [WORD_WIDTH-1:0] idx2,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] q1,
    output logic [WORD_WIDTH-1:0] q2,
    output logic [WORD_WIDTH-1:0] rem1,
    output logic [WORD_WIDTH-1:0] rem2
);

    logic [WORD_WIDTH-1:0] kw_q, kw_d;
    logic [WORD_WIDTH-1:0] q1_q, q1_d, q2_q, q2_d;
    logic [WORD_WIDTH-1:0] rem1_q, rem1_d, rem2_q, rem2_d;
    logic                  done_q, done_d;

    always_comb begin
        kw_d   = kw_q;
        q1_d   = q1_q;
        q2_d   = q2_q;
        rem1_d = rem1_q;
        rem2_d = rem2_q;
        done_d = done_q;
        if (start) begin
            kw_d   = kw;
            rem1_d = idx1;
            rem2_d = idx2;
            q1_d   = '0;
            q2_d   = '0;
            done_d = 1'b0;
        end else if (!done_q) begin
            // A zero divisor finishes immediately so the loop can never run forever.
            if ((kw_q == '0) || ((rem1_q < kw_q) && (rem2_q < kw_q))) begin
                done_d = 1'b1;
            end else begin
                if (rem1_q >= kw_q) begin
                    rem1_d = rem1_q - kw_q;
                    q1_d   = q1_q + 1'b1;
                end
                if (rem2_q >= kw_q) begin
                    rem2_d = rem2_q - kw_q;
                    q2_d   = q2_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kw_q   <= '0;
            q1_q   <= '0;
            q2_q   <= '0;
            rem1_q <= '0;
            rem2_q <= '0;
            done_q <= 1'b0;
        end else begin
            kw_q   <= kw_d;
            q1_q   <= q1_d;
            q2_q   <= q2_d;
            rem1_q <= rem1_d;
            rem2_q <= rem2_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign q1   = q1_q;
    assign q2   = q2_q;
    assign rem1 = rem1_q;
    assign rem2 = rem2_q;

endmodule

// File: rtl/dist_calc_arbiter.sv
// Round-robin arbiter sharing one distance-calculation divider among NUM_REQ requesters.
// Computes vdist = idx2/FW - idx1/FW and hdist = idx2%FW - idx1%FW (mod 2^W).
//   clk, reset_n         : clock and asynchronous active-low reset
//   ke_width             : kernel width FW, latched at request handshake
//   req_valid/req_ready  : per-requester request channel (at most one ready bit)
//   req_idx1/req_idx2    : packed indices, requester r at [r*W +: W]
//   rsp_valid/rsp_ready  : one-hot response channel to the granted requester
//   rsp_vdist/rsp_hdist  : result distances
//   rsp_err              : latched FW was zero, distances forced to zero
//   busy                 : FSM not idle
//   grant_id             : current or last granted requester
module dist_calc_arbiter
    import rc_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned WORD_WIDTH = RC_WORD_WIDTH,
    localparam int unsigned GID_W     = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [WORD_WIDTH-1:0]         ke_width,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_idx1,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_idx2,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [WORD_WIDTH-1:0]         rsp_vdist,
    output logic [WORD_WIDTH-1:0]         rsp_hdist,
    output logic                          rsp_err,
    output logic                          busy,
    output logic [GID_W-1:0]              grant_id
);

    dca_state_t            state_q, state_d;
    logic [GID_W-1:0]      last_grant_q, last_grant_d;
    logic [GID_W-1:0]      grant_id_q, grant_id_d;
    logic [WORD_WIDTH-1:0] vdist_q, vdist_d, hdist_q, hdist_d;
    logic                  err_q, err_d;
    logic                  kw_zero_q, kw_zero_d;

    logic [GID_W-1:0]      pick;
    logic [WORD_WIDTH-1:0] sel_idx1, sel_idx2;
    logic                  div_start, div_done;
    logic [WORD_WIDTH-1:0] div_q1, div_q2, div_rem1, div_rem2;

    assign pick     = GID_W'(rr_pick(RC_MAX_REQ'(req_valid), 5'(last_grant_q), NUM_REQ));
    assign sel_idx1 = req_idx1[pick*WORD_WIDTH +: WORD_WIDTH];
    assign sel_idx2 = req_idx2[pick*WORD_WIDTH +: WORD_WIDTH];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        vdist_d      = vdist_q;
        hdist_d      = hdist_q;
        err_d        = err_q;
        kw_zero_d    = kw_zero_q;
        div_start    = 1'b0;
        req_ready    = '0;
        rsp_valid    = '0;
        unique case (state_q)
            DCA_IDLE: begin
                // Winner is always valid, so asserting its ready is the handshake.
                if (|req_valid) begin
                    req_ready[pick] = 1'b1;
                    div_start       = 1'b1;
                    last_grant_d    = pick;
                    grant_id_d      = pick;
                    kw_zero_d       = (ke_width == '0);
                    state_d         = DCA_DIV;
                end
            end
            DCA_DIV: begin
                if (div_done) begin
                    if (kw_zero_q) begin
                        vdist_d = '0;
                        hdist_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        vdist_d = div_q2 - div_q1;
                        hdist_d = div_rem2 - div_rem1;
                        err_d   = 1'b0;
                    end
                    state_d = DCA_RESP;
                end
            end
            DCA_RESP: begin
                rsp_valid[grant_id_q] = 1'b1;
                if (rsp_ready[grant_id_q]) begin
                    vdist_d = '0;
                    hdist_d = '0;
                    err_d   = 1'b0;
                    state_d = DCA_IDLE;
                end
            end
            default: state_d = DCA_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= DCA_IDLE;
            last_grant_q <= GID_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            vdist_q      <= '0;
            hdist_q      <= '0;
            err_q        <= 1'b0;
            kw_zero_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            vdist_q      <= vdist_d;
            hdist_q      <= hdist_d;
            err_q        <= err_d;
            kw_zero_q    <= kw_zero_d;
        end
    end

    dual_idx_divider #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_divider (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (div_start),
        .kw      (ke_width),
        .idx1    (sel_idx1),
        .idx2    (sel_idx2),
        .done    (div_done),
        .q1      (div_q1),
        .q2      (div_q2),
        .rem1    (div_rem1),
        .rem2    (div_rem2)
    );

    assign rsp_vdist = vdist_q;
    assign rsp_hdist = hdist_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != DCA_IDLE);
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_dist_calc_arbiter.sv
module tb_dist_calc_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned GW = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [W-1:0]    ke_width;
    logic [NR-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*W-1:0] req_idx1, req_idx2;
    logic [W-1:0]    rsp_vdist, rsp_hdist;
    logic            rsp_err, busy;
    logic [GW-1:0]   grant_id;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          rq;
        logic [W-1:0] v;
        logic [W-1:0] h;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    dist_calc_arbiter #(
        .NUM_REQ    (NR),
        .WORD_WIDTH (W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ke_width  (ke_width),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx1  (req_idx1),
        .req_idx2  (req_idx2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_vdist (rsp_vdist),
        .rsp_hdist (rsp_hdist),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer division, independent of the subtract loop.
    function automatic exp_t model(input int rq, input logic [W-1:0] i1, input logic [W-1:0] i2,
                                   input logic [W-1:0] fw);
        exp_t e;
        e.rq = rq;
        if (fw == '0) begin
            e.v   = '0;
            e.h   = '0;
            e.err = 1'b1;
            e.lat = 2;
        end else begin
            e.v   = (i2 / fw) - (i1 / fw);
            e.h   = (i2 % fw) - (i1 % fw);
            e.err = 1'b0;
            e.lat = ((i1 / fw) > (i2 / fw) ? int'(i1 / fw) : int'(i2 / fw)) + 2;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic [W-1:0] i1, input logic [W-1:0] i2);
        req_idx1[r*W +: W] = i1;
        req_idx2[r*W +: W] = i2;
        req_valid[r]       = 1'b1;
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Raise a request and wait for its handshake edge; hs = cycle count after that edge.
    task automatic request(input int r, input logic [W-1:0] i1, input logic [W-1:0] i2,
                           input logic [W-1:0] fw, output int hs);
        drive(r, i1, i2);
        ke_width = fw;
        hs = -1;
        for (int k = 0; k < 40 && hs < 0; k++) begin
            #1;
            if (req_ready[r] === 1'b1) begin
                tick();
                hs = cyc;
                req_valid[r] = 1'b0;
            end else begin
                tick();
            end
        end
        check("handshake_seen", 32'(hs >= 0), 1);
        check("grant_id", 32'(grant_id), r);
    endtask

    task automatic wait_rsp(output int got);
        got = 0;
        for (int k = 0; k < 300 && got == 0; k++) begin
            if (rsp_valid !== '0) got = 1;
            else tick();
        end
        check("rsp_seen", got, 1);
    endtask

    task automatic check_rsp(input int hs, output exp_t e);
        check("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'(1) << e.rq);
            check("rsp_vdist", 32'(rsp_vdist), 32'(e.v));
            check("rsp_hdist", 32'(rsp_hdist), 32'(e.h));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            if (hs >= 0) check("latency", cyc - hs, e.lat);
        end
    endtask

    task automatic collect(input int hs);
        int   got;
        exp_t e;
        wait_rsp(got);
        if (got != 0) begin
            check_rsp(hs, e);
            rsp_ready[e.rq] = 1'b1;
            tick();
            rsp_ready = '0;
            check("rsp_valid_after_hs", 32'(rsp_valid), 0);
            check("rsp_err_after_hs", 32'(rsp_err), 0);
            check("busy_after_hs", 32'(busy), 0);
        end
    endtask

    initial begin
        int   hs;
        int   got;
        exp_t e;
        reset_n   = 1'b0;
        ke_width  = '0;
        req_valid = '0;
        rsp_ready = '0;
        req_idx1  = '0;
        req_idx2  = '0;
        tick();
        tick();

        // Reset state
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_err", 32'(rsp_err), 0);
        check("rst_vdist", 32'(rsp_vdist), 0);
        reset_n = 1'b1;
        tick();

        // Single request, FW=3, r1: vdist=2, hdist=0, latency 4
        sb.push_back(model(1, 8'd1, 8'd7, 8'd3));
        request(1, 8'd1, 8'd7, 8'd3, hs);
        check("busy_div", 32'(busy), 1);
        collect(hs);

        // Negative distances wrap; ke_width change after handshake must be ignored
        sb.push_back(model(0, 8'd8, 8'd2, 8'd3));
        request(0, 8'd8, 8'd2, 8'd3, hs);
        ke_width = 8'd1;
        collect(hs);

        // FW=0 on r2: error response after 2 cycles
        sb.push_back(model(2, 8'd5, 8'd9, 8'd0));
        request(2, 8'd5, 8'd9, 8'd0, hs);
        collect(hs);

        // Stalled response with competing requests pending
        sb.push_back(model(3, 8'd3, 8'd10, 8'd4));
        request(3, 8'd3, 8'd10, 8'd4, hs);
        wait_rsp(got);
        if (got != 0) begin
            check_rsp(hs, e);
            drive(0, 8'd0, 8'd0);
            drive(1, 8'd0, 8'd0);
            rsp_ready = 4'b0111;
            for (int k = 0; k < 5; k++) begin
                #1;
                check("stall_req_ready", 32'(req_ready), 0);
                check("stall_busy", 32'(busy), 1);
                check("stall_rsp_valid", 32'(rsp_valid), 32'h8);
                check("stall_vdist", 32'(rsp_vdist), 32'(e.v));
                check("stall_hdist", 32'(rsp_hdist), 32'(e.h));
                tick();
            end
            rsp_ready = 4'b1000;
            tick();
            rsp_ready = '0;
            check("stall_release_valid", 32'(rsp_valid), 0);
            check("stall_release_err", 32'(rsp_err), 0);
            #1;
            check("next_grant_r0", 32'(req_ready), 32'h1);
            req_valid = '0;
            tick();
            check("no_grant_taken", 32'(busy), 0);
        end

        // Round robin with all requesters held valid
        apply_reset();
        ke_width  = 8'd3;
        rsp_ready = '1;
        for (int r = 0; r < 4; r++) drive(r, 8'd0, 8'd5);
        sb.push_back(model(0, 8'd0, 8'd5, 8'd3));
        sb.push_back(model(1, 8'd0, 8'd5, 8'd3));
        sb.push_back(model(2, 8'd0, 8'd5, 8'd3));
        sb.push_back(model(3, 8'd0, 8'd5, 8'd3));
        sb.push_back(model(0, 8'd0, 8'd5, 8'd3));
        got = 0;
        for (int k = 0; k < 200 && got < 5; k++) begin
            if (rsp_valid !== '0) begin
                check_rsp(-1, e);
                got++;
                if (got == 5) req_valid = '0;
            end
            tick();
        end
        check("rr_count", got, 5);
        rsp_ready = '0;
        tick();

        // Reset asserted mid-DIV discards the result
        request(2, 8'd0, 8'd200, 8'd3, hs);
        tick();
        tick();
        check("pre_rst_busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_grant_id", 32'(grant_id), 0);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("no_stale_rsp", 32'(rsp_valid), 0);
        end
        drive(1, 8'd4, 8'd6);
        drive(0, 8'd2, 8'd9);
        #1;
        check("post_rst_winner", 32'(req_ready), 32'h1);
        sb.push_back(model(0, 8'd2, 8'd9, 8'd3));
        request(0, 8'd2, 8'd9, 8'd3, hs);
        req_valid = '0;
        collect(hs);

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
